// File: rtl/axi_rr_arbiter.sv
// AXI-lite N:1 arbiter: one transaction at a time, round-robin or fixed priority.
// Only the granted master is forwarded; nothing is buffered.
module axi_rr_arbiter #(
   parameter int NUM_M     = 2,
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int PRIO_MODE = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_M*AW-1:0]       m_araddr,
   input  logic [NUM_M-1:0]          m_arvalid,
   output logic [NUM_M-1:0]          m_arready,
   output logic [NUM_M*DW-1:0]       m_rdata,
   output logic [NUM_M*2-1:0]        m_rresp,
   output logic [NUM_M-1:0]          m_rvalid,
   input  logic [NUM_M-1:0]          m_rready,
   input  logic [NUM_M*AW-1:0]       m_awaddr,
   input  logic [NUM_M-1:0]          m_awvalid,
   output logic [NUM_M-1:0]          m_awready,
   input  logic [NUM_M*DW-1:0]       m_wdata,
   input  logic [NUM_M*DW/8-1:0]     m_wstrb,
   input  logic [NUM_M-1:0]          m_wvalid,
   output logic [NUM_M-1:0]          m_wready,
   output logic [NUM_M*2-1:0]        m_bresp,
   output logic [NUM_M-1:0]          m_bvalid,
   input  logic [NUM_M-1:0]          m_bready,
   output logic [AW-1:0]             s_araddr,
   output logic                      s_arvalid,
   input  logic                      s_arready,
   input  logic [DW-1:0]             s_rdata,
   input  logic [1:0]                s_rresp,
   input  logic                      s_rvalid,
   output logic                      s_rready,
   output logic [AW-1:0]             s_awaddr,
   output logic                      s_awvalid,
   input  logic                      s_awready,
   output logic [DW-1:0]             s_wdata,
   output logic [DW/8-1:0]           s_wstrb,
   output logic                      s_wvalid,
   input  logic                      s_wready,
   input  logic [1:0]                s_bresp,
   input  logic                      s_bvalid,
   output logic                      s_bready,
   output logic [$clog2(NUM_M)-1:0]  grant_id,
   output logic                      busy
);

   localparam int GW = $clog2(NUM_M);
   localparam int SW = DW / 8;

   typedef enum logic [2:0] {
      IDLE,
      RADDR,
      RDATA,
      WREQ,
      WRESP
   } state_t;

   state_t         state;
   state_t         state_n;
   logic [GW-1:0]  grant_n;
   logic [GW-1:0]  last_grant;
   logic [GW-1:0]  last_n;
   logic           aw_done;
   logic           aw_done_n;
   logic           w_done;
   logic           w_done_n;

   logic [NUM_M-1:0] req;
   logic [NUM_M-1:0] gsel;
   logic [GW-1:0]    win;
   logic [GW-1:0]    sel;
   logic             found;
   int               idx;

   logic ar_hs;
   logic r_hs;
   logic aw_hs;
   logic w_hs;
   logic b_hs;

   logic [AW-1:0] ar_addr [NUM_M];
   logic [AW-1:0] aw_addr [NUM_M];
   logic [DW-1:0] w_data  [NUM_M];
   logic [SW-1:0] w_strb  [NUM_M];

   for (genvar i = 0; i < NUM_M; i++) begin : g_slice
      assign ar_addr[i] = m_araddr[i*AW +: AW];
      assign aw_addr[i] = m_awaddr[i*AW +: AW];
      assign w_data[i]  = m_wdata[i*DW +: DW];
      assign w_strb[i]  = m_wstrb[i*SW +: SW];
   end

   assign m_rdata = {NUM_M{s_rdata}};
   assign m_rresp = {NUM_M{s_rresp}};
   assign m_bresp = {NUM_M{s_bresp}};

   assign s_araddr = ar_addr[grant_id];
   assign s_awaddr = aw_addr[grant_id];
   assign s_wdata  = w_data[grant_id];
   assign s_wstrb  = w_strb[grant_id];

   assign req  = m_arvalid | m_awvalid;
   assign gsel = NUM_M'(1) << grant_id;
   assign busy = (state != IDLE);

   assign ar_hs = s_arvalid & s_arready;
   assign r_hs  = s_rvalid  & s_rready;
   assign aw_hs = s_awvalid & s_awready;
   assign w_hs  = s_wvalid  & s_wready;
   assign b_hs  = s_bvalid  & s_bready;

   // Round-robin scans from last_grant+1 with wrap; fixed mode scans from 0.
   always_comb begin
      win   = '0;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int k = 0; k < NUM_M; k++) begin
         if (PRIO_MODE == 1) begin
            idx = k;
         end else begin
            idx = (int'(last_grant) + 1 + k) % NUM_M;
         end
         sel = GW'(idx);
         if (!found && req[sel]) begin
            found = 1'b1;
            win   = sel;
         end
      end
   end

   always_comb begin
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
      s_awvalid = 1'b0;
      s_wvalid  = 1'b0;
      s_bready  = 1'b0;
      m_arready = '0;
      m_rvalid  = '0;
      m_awready = '0;
      m_wready  = '0;
      m_bvalid  = '0;
      case (state)
         RADDR: begin
            s_arvalid = m_arvalid[grant_id];
            m_arready = s_arready ? gsel : '0;
         end
         RDATA: begin
            s_rready = m_rready[grant_id];
            m_rvalid = s_rvalid ? gsel : '0;
         end
         WREQ: begin
            // A finished channel stays quiet until the write response.
            s_awvalid = m_awvalid[grant_id] & ~aw_done;
            s_wvalid  = m_wvalid[grant_id] & ~w_done;
            m_awready = (s_awready && !aw_done) ? gsel : '0;
            m_wready  = (s_wready && !w_done) ? gsel : '0;
         end
         WRESP: begin
            s_bready = m_bready[grant_id];
            m_bvalid = s_bvalid ? gsel : '0;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_n   = state;
      grant_n   = grant_id;
      last_n    = last_grant;
      aw_done_n = aw_done;
      w_done_n  = w_done;
      case (state)
         IDLE: begin
            if (found) begin
               grant_n = win;
               state_n = m_arvalid[win] ? RADDR : WREQ;
            end
         end
         RADDR: begin
            if (ar_hs) state_n = RDATA;
         end
         RDATA: begin
            if (r_hs) begin
               state_n = IDLE;
               last_n  = grant_id;
            end
         end
         WREQ: begin
            aw_done_n = aw_done | aw_hs;
            w_done_n  = w_done | w_hs;
            if (aw_done_n && w_done_n) state_n = WRESP;
         end
         WRESP: begin
            if (b_hs) begin
               state_n   = IDLE;
               last_n    = grant_id;
               aw_done_n = 1'b0;
               w_done_n  = 1'b0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= GW'(NUM_M - 1);
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
      end else begin
         state      <= state_n;
         grant_id   <= grant_n;
         last_grant <= last_n;
         aw_done    <= aw_done_n;
         w_done     <= w_done_n;
      end
   end

endmodule

// File: tb/tb_axi_rr_arbiter.sv
// Bench for axi_rr_arbiter: 3-master round-robin DUT with scoreboard,
// plus a 4-master fixed-priority DUT under continuous requests.
module tb_axi_rr_arbiter;

   localparam logic [31:0] KEY = 32'h5A5A_0000;

   typedef struct {
      logic        wr;
      logic [1:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [31:0] ar_addr_a [3];
   logic [31:0] aw_addr_a [3];
   logic [31:0] w_data_a  [3];
   logic [3:0]  w_strb_a  [3];

   logic [95:0] m_araddr, m_awaddr, m_wdata, m_rdata;
   logic [11:0] m_wstrb;
   logic [5:0]  m_rresp, m_bresp;
   logic [2:0]  m_arvalid, m_arready, m_rvalid, m_rready;
   logic [2:0]  m_awvalid, m_awready, m_wvalid, m_wready;
   logic [2:0]  m_bvalid, m_bready;
   logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
   logic [3:0]  s_wstrb;
   logic [1:0]  s_rresp, s_bresp, grant_id;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic        s_awvalid, s_awready, s_wvalid, s_wready;
   logic        s_bvalid, s_bready, busy;

   assign m_araddr = {ar_addr_a[2], ar_addr_a[1], ar_addr_a[0]};
   assign m_awaddr = {aw_addr_a[2], aw_addr_a[1], aw_addr_a[0]};
   assign m_wdata  = {w_data_a[2], w_data_a[1], w_data_a[0]};
   assign m_wstrb  = {w_strb_a[2], w_strb_a[1], w_strb_a[0]};

   logic [31:0] rdata_a [3];
   logic [1:0]  rresp_a [3];
   logic [1:0]  bresp_a [3];
   assign rdata_a[0] = m_rdata[31:0];
   assign rdata_a[1] = m_rdata[63:32];
   assign rdata_a[2] = m_rdata[95:64];
   assign rresp_a[0] = m_rresp[1:0];
   assign rresp_a[1] = m_rresp[3:2];
   assign rresp_a[2] = m_rresp[5:4];
   assign bresp_a[0] = m_bresp[1:0];
   assign bresp_a[1] = m_bresp[3:2];
   assign bresp_a[2] = m_bresp[5:4];

   axi_rr_arbiter #(
      .NUM_M(3), .AW(32), .DW(32), .PRIO_MODE(0)
   ) u_dut (
      .clk(clk), .rst(rst),
      .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
      .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid),
      .m_rready(m_rready),
      .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
      .m_wready(m_wready),
      .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
      .s_rready(s_rready),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid),
      .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .grant_id(grant_id), .busy(busy)
   );

   logic [3:0]   b_arvalid, b_arready, b_rvalid, b_awready, b_wready, b_bvalid;
   logic [127:0] b_rdata;
   logic [7:0]   b_rresp, b_bresp;
   logic [31:0]  b_s_araddr, b_s_awaddr, b_s_wdata;
   logic [3:0]   b_s_wstrb;
   logic         b_s_arvalid, b_s_rready, b_s_awvalid, b_s_wvalid;
   logic         b_s_bready, b_busy;
   logic [1:0]   b_gid;

   axi_rr_arbiter #(
      .NUM_M(4), .AW(32), .DW(32), .PRIO_MODE(1)
   ) u_fix (
      .clk(clk), .rst(rst),
      .m_araddr('0), .m_arvalid(b_arvalid), .m_arready(b_arready),
      .m_rdata(b_rdata), .m_rresp(b_rresp), .m_rvalid(b_rvalid),
      .m_rready(4'hF),
      .m_awaddr('0), .m_awvalid(4'h0), .m_awready(b_awready),
      .m_wdata('0), .m_wstrb('0), .m_wvalid(4'h0), .m_wready(b_wready),
      .m_bresp(b_bresp), .m_bvalid(b_bvalid), .m_bready(4'h0),
      .s_araddr(b_s_araddr), .s_arvalid(b_s_arvalid), .s_arready(1'b1),
      .s_rdata(32'h0), .s_rresp(2'b00), .s_rvalid(1'b1),
      .s_rready(b_s_rready),
      .s_awaddr(b_s_awaddr), .s_awvalid(b_s_awvalid), .s_awready(1'b0),
      .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb), .s_wvalid(b_s_wvalid),
      .s_wready(1'b0),
      .s_bresp(2'b00), .s_bvalid(1'b0), .s_bready(b_s_bready),
      .grant_id(b_gid), .busy(b_busy)
   );

   int total = 0;
   int bad = 0;
   exp_t sb[$];

   logic [31:0] rd_addr_q, got_awaddr, got_wdata;
   logic [3:0]  got_wstrb;
   logic        wr_aw, wr_w;
   int          aw_cnt, w_cnt, wwait, wdelay;
   logic        b_prev;
   int          b_low, b_rises;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sb_read();
      exp_t e;
      if (sb.size() == 0) begin
         check("rd_extra", m_rvalid, 0);
      end else begin
         e = sb.pop_front();
         check("rd_vec", m_rvalid, e.wr ? 3'b000 : (3'b001 << e.id));
         check("rdata", rdata_a[e.id], e.data);
         check("rresp", rresp_a[e.id], e.resp);
      end
   endtask

   task automatic sb_write();
      exp_t e;
      if (sb.size() == 0) begin
         check("wr_extra", m_bvalid, 0);
      end else begin
         e = sb.pop_front();
         check("b_vec", m_bvalid, e.wr ? (3'b001 << e.id) : 3'b000);
         check("bresp", bresp_a[e.id], e.resp);
      end
   endtask

   // One clock: observe at negedge, update master/slave models after posedge.
   task automatic step();
      logic [2:0] ar_hs, aw_hs, w_hs;
      logic sar, sr, saw, sw, sbh;
      @(negedge clk);
      ar_hs = m_arvalid & m_arready;
      aw_hs = m_awvalid & m_awready;
      w_hs  = m_wvalid & m_wready;
      sar = s_arvalid & s_arready;
      sr  = s_rvalid & s_rready;
      saw = s_awvalid & s_awready;
      sw  = s_wvalid & s_wready;
      sbh = s_bvalid & s_bready;
      if (sar) rd_addr_q = s_araddr;
      if (saw) begin
         aw_cnt++;
         got_awaddr = s_awaddr;
      end
      if (sw) begin
         w_cnt++;
         got_wdata = s_wdata;
         got_wstrb = s_wstrb;
         wwait = 0;
      end else if (s_wvalid) begin
         wwait++;
      end
      if ((m_rvalid & m_rready) != 0) sb_read();
      if ((m_bvalid & m_bready) != 0) sb_write();
      if (!busy) begin
         check("idle_out", {s_arvalid, s_awvalid, s_wvalid, s_rready,
               s_bready, m_arready, m_rvalid, m_awready, m_wready,
               m_bvalid}, 0);
      end
      if (b_busy) begin
         if (!b_prev) begin
            check("b_gid", b_gid, 0);
            if (b_rises > 0) check("b_gap", b_low, 1);
            b_rises++;
         end
         b_low = 0;
      end else begin
         b_low++;
      end
      b_prev = b_busy;
      @(posedge clk);
      #1;
      m_arvalid = m_arvalid & ~ar_hs;
      m_awvalid = m_awvalid & ~aw_hs;
      m_wvalid  = m_wvalid & ~w_hs;
      if (sr) s_rvalid = 1'b0;
      if (sar) begin
         s_rvalid = 1'b1;
         s_rdata  = rd_addr_q ^ KEY;
         s_rresp  = rd_addr_q[5:4];
      end
      if (saw) wr_aw = 1'b1;
      if (sw) wr_w = 1'b1;
      if (sbh) begin
         s_bvalid = 1'b0;
      end else if (wr_aw && wr_w) begin
         s_bvalid = 1'b1;
         s_bresp  = got_awaddr[3:2];
         wr_aw    = 1'b0;
         wr_w     = 1'b0;
      end
      s_wready = (wwait >= wdelay);
   endtask

   task automatic rd(input logic [1:0] id, input logic [31:0] a,
                     input bit push);
      ar_addr_a[id] = a;
      m_arvalid[id] = 1'b1;
      if (push) sb.push_back('{1'b0, id, a ^ KEY, a[5:4]});
   endtask

   task automatic wr(input logic [1:0] id, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] st);
      aw_addr_a[id] = a;
      w_data_a[id]  = d;
      w_strb_a[id]  = st;
      m_awvalid[id] = 1'b1;
      m_wvalid[id]  = 1'b1;
      sb.push_back('{1'b1, id, 32'h0, a[3:2]});
   endtask

   task automatic drain(input int maxc);
      int c = 0;
      while (sb.size() != 0 && c < maxc) begin
         step();
         c++;
      end
      check("drain", sb.size(), 0);
      step();
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ar_addr_a[i] = '0;
         aw_addr_a[i] = '0;
         w_data_a[i]  = '0;
         w_strb_a[i]  = '0;
      end
      m_arvalid = '0; m_awvalid = '0; m_wvalid = '0;
      m_rready = 3'b111; m_bready = 3'b111;
      s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
      s_rvalid = 1'b0; s_rdata = '0; s_rresp = '0;
      s_bvalid = 1'b0; s_bresp = '0;
      rd_addr_q = '0; got_awaddr = '0; got_wdata = '0; got_wstrb = '0;
      wr_aw = 1'b0; wr_w = 1'b0;
      aw_cnt = 0; w_cnt = 0; wwait = 0; wdelay = 0;
      b_arvalid = '0; b_prev = 1'b0; b_low = 0; b_rises = 0;

      #12;
      m_arvalid[1] = 1'b1;
      #1;
      check("rst_busy", busy, 0);
      check("rst_gid", grant_id, 0);
      check("rst_mready", {m_arready, m_awready, m_wready}, 0);
      check("rst_svalid", {s_arvalid, s_awvalid, s_wvalid, s_rready}, 0);
      check("rst_mvalid", {m_rvalid, m_bvalid}, 0);
      m_arvalid[1] = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      b_arvalid = 4'hF;
      step();
      step();

      rd(2'd0, 32'h0000_1010, 1'b1);
      rd(2'd1, 32'h0000_2020, 1'b1);
      drain(30);
      rd(2'd0, 32'h0000_3030, 1'b1);
      drain(20);

      rd(2'd2, 32'h4000_0004, 1'b1);
      drain(20);
      rd(2'd0, 32'h0000_5000, 1'b1);
      rd(2'd2, 32'h6000_0010, 1'b1);
      drain(30);

      rd(2'd0, 32'h7000_0020, 1'b1);
      wr(2'd0, 32'h8000_000C, 32'hDEAD_BEEF, 4'hF);
      drain(30);

      aw_cnt = 0;
      w_cnt = 0;
      wdelay = 3;
      w_data_a[1] = 32'hCAFE_F00D;
      w_strb_a[1] = 4'b0110;
      m_wvalid[1] = 1'b1;
      step();
      step();
      aw_addr_a[1] = 32'h9000_0004;
      m_awvalid[1] = 1'b1;
      sb.push_back('{1'b1, 2'd1, 32'h0, 2'b01});
      drain(30);
      check("aw_count", aw_cnt, 1);
      check("w_count", w_cnt, 1);
      check("s_awaddr", got_awaddr, 32'h9000_0004);
      check("s_wdata", got_wdata, 32'hCAFE_F00D);
      check("s_wstrb", got_wstrb, 4'b0110);
      wdelay = 0;

      m_rready[2] = 1'b0;
      rd(2'd2, 32'hC000_0000, 1'b0);
      for (int c = 0; c < 10 && !m_rvalid[2]; c++) step();
      check("abort_pre", m_rvalid[2], 1);
      #2;
      rst = 1'b0;
      #1;
      check("abort_rvalid", m_rvalid, 0);
      check("abort_busy", busy, 0);
      check("abort_gid", grant_id, 0);
      check("abort_sready", {s_rready, s_arvalid}, 0);
      @(negedge clk);
      s_rvalid = 1'b0;
      m_rready = 3'b111;
      wr_aw = 1'b0;
      wr_w = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      b_prev = 1'b0;
      b_low = 0;
      b_rises = 0;
      repeat (5) step();
      check("no_replay", busy, 0);

      rd(2'd1, 32'hA000_0030, 1'b1);
      rd(2'd2, 32'hB000_0000, 1'b1);
      drain(30);
      check("b_rises", b_rises > 3, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
